bsg_mesh_proc_sink: RTL and testbench

// - Synthesizable receiver on a mesh router's proc (P) output port; counterpart of the injector side.
// - Accepts packets with a ready-then-valid handshake and checks three things:
//   the packet is addressed to this tile, the source is legal, and the per-source sequence number is in order.
// - Counts accepted packets, raises done_o when the programmed total has arrived, and latches the first error.
// - Intended use: on-chip/FPGA mesh traffic tests, one instance per tile.
//

---
 rtl/bsg_mesh_proc_sink_pkg.sv | 17 +
 rtl/bsg_mesh_proc_sink_seq_table.sv | 38 +++
 rtl/bsg_mesh_proc_sink.sv | 123 ++++++++++++
 tb/tb_bsg_mesh_proc_sink.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_mesh_proc_sink_pkg.sv
// bsg_mesh_proc_sink_pkg: shared FSM state, error codes and packet width helper for the proc sink.
package bsg_mesh_proc_sink_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

    typedef enum logic [1:0] {
        e_none = 2'd0,
        e_dest = 2'd1,
        e_src  = 2'd2,
        e_seq  = 2'd3
    } err_code_e;

    function automatic int pkt_width(int x_w, int y_w, int seq_w);
        return seq_w + 2 * (x_w + y_w);
    endfunction

endpackage

// File: rtl/bsg_mesh_proc_sink_seq_table.sv
// bsg_mesh_proc_sink_seq_table: per-source expected-sequence flops with a registered write and read bypass.
module bsg_mesh_proc_sink_seq_table #(
    parameter int addr_width_p = 4,
    parameter int data_width_p = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [addr_width_p-1:0] r_addr,
    output logic [data_width_p-1:0] r_data,
    input  logic                    w_v,
    input  logic [addr_width_p-1:0] w_addr,
    input  logic [data_width_p-1:0] w_data
);
    localparam int els_lp = 2 ** addr_width_p;

    logic [data_width_p-1:0] mem_r [els_lp];
    logic                    pend_v_r;
    logic [addr_width_p-1:0] pend_addr_r;
    logic [data_width_p-1:0] pend_data_r;

    // Writes land one cycle late, so a same-source packet right behind must see the pending value.
    assign r_data = (pend_v_r && pend_addr_r == r_addr) ? pend_data_r : mem_r[r_addr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend_v_r    <= 1'b0;
            pend_addr_r <= '0;
            pend_data_r <= '0;
            for (int i = 0; i < els_lp; i++) mem_r[i] <= '0;
        end else begin
            pend_v_r    <= w_v;
            pend_addr_r <= w_addr;
            pend_data_r <= w_data;
            if (pend_v_r) mem_r[pend_addr_r] <= pend_data_r;
        end
    end

endmodule

// File: rtl/bsg_mesh_proc_sink.sv
// bsg_mesh_proc_sink: mesh P-port receiver checking dest, src and per-source sequence order.
// Define BSG_MESH_PROC_SINK_STALL_EN for LFSR-driven random backpressure.
module bsg_mesh_proc_sink
    import bsg_mesh_proc_sink_pkg::*;
#(
    parameter int         x_cord_width_p = 2,
    parameter int         y_cord_width_p = 2,
    parameter int         seq_width_p    = 4,
    parameter int         count_width_p  = 8,
    parameter logic [7:0] stall_seed_p   = 8'hA5,
    localparam int        cord_w_lp      = x_cord_width_p + y_cord_width_p,
    localparam int        width_lp       = pkt_width(x_cord_width_p, y_cord_width_p, seq_width_p)
) (
    input  logic                      clk_i,
    input  logic                      reset_n_i,
    input  logic                      en_i,
    input  logic [x_cord_width_p-1:0] my_x_i,
    input  logic [y_cord_width_p-1:0] my_y_i,
    input  logic [count_width_p-1:0]  expected_pkts_i,
    input  logic                      v_i,
    input  logic [width_lp-1:0]       data_i,
    output logic                      ready_o,
    output logic [count_width_p-1:0]  pkt_count_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [1:0]                err_code_o,
    output logic [cord_w_lp-1:0]      err_src_o
);
    localparam int num_src_lp = 2 ** cord_w_lp;

    typedef struct packed {
        logic [seq_width_p-1:0] seq;
        logic [cord_w_lp-1:0]   src;
        logic [cord_w_lp-1:0]   dest;
    } pkt_s;

    pkt_s                     pkt;
    state_e                   state_r, state_n;
    err_code_e                code, code_r;
    logic [count_width_p-1:0] cnt_r, total_r, cnt_inc;
    logic [cord_w_lp-1:0]     src_r;
    logic [seq_width_p-1:0]   exp_seq;
    logic                     stall_r, accept, err_r;

    assign pkt     = data_i;
    assign ready_o = state_r == RUN && !stall_r;
    assign accept  = v_i && ready_o;
    assign cnt_inc = &cnt_r ? cnt_r : cnt_r + 1'b1;
    // The src check is unreachable at full field width but stays as a guard for narrower id spaces.
    assign code    = pkt.dest != {my_y_i, my_x_i}                         ? e_dest :
                     {1'b0, pkt.src} >= (cord_w_lp + 1)'(num_src_lp)     ? e_src  :
                     pkt.seq != exp_seq                                   ? e_seq  : e_none;

    assign pkt_count_o = cnt_r;
    assign done_o      = state_r == DONE;
    assign err_o       = err_r;
    assign err_code_o  = code_r;
    assign err_src_o   = src_r;

    bsg_mesh_proc_sink_seq_table #(
        .addr_width_p(cord_w_lp),
        .data_width_p(seq_width_p)
    ) seq_table (
        .clk    (clk_i),
        .reset_n(reset_n_i),
        .r_addr (pkt.src),
        .r_data (exp_seq),
        .w_v    (accept),
        .w_addr (pkt.src),
        .w_data (pkt.seq + 1'b1)
    );

    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE:    if (en_i) state_n = expected_pkts_i == '0 ? DONE : RUN;
            RUN:     if (accept && cnt_inc == total_r) state_n = DONE;
            default: state_n = state_r;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            total_r <= '0;
            err_r   <= 1'b0;
            code_r  <= e_none;
            src_r   <= '0;
        end else begin
            state_r <= state_n;
            if (state_r == IDLE && en_i) total_r <= expected_pkts_i;
            if (accept) cnt_r <= cnt_inc;
            if (accept && code != e_none && !err_r) begin
                err_r  <= 1'b1;
                code_r <= code;
                src_r  <= pkt.src;
            end
        end
    end

`ifdef BSG_MESH_PROC_SINK_STALL_EN
    logic [7:0] lfsr_r;

    // x^8+x^6+x^5+x^4+1, maximal length
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            lfsr_r  <= stall_seed_p;
            stall_r <= 1'b0;
        end else if (state_r == RUN) begin
            lfsr_r  <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
            stall_r <= lfsr_r[1:0] == 2'b00;
        end else begin
            stall_r <= 1'b0;
        end
    end
`else
    logic unused_seed;
    assign stall_r     = 1'b0;
    assign unused_seed = ^stall_seed_p;
`endif

endmodule

// File: tb/tb_bsg_mesh_proc_sink.sv
// tb_bsg_mesh_proc_sink: randomized scoreboard bench for bsg_mesh_proc_sink against a packet-level model.
module tb_bsg_mesh_proc_sink;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic        en_i = 1'b0;
    logic [1:0]  my_x_i = '0, my_y_i = '0;
    logic [7:0]  expected_pkts_i = '0;
    logic        v_i = 1'b0;
    logic [11:0] data_i = '0;
    logic        ready_o, done_o, err_o;
    logic [7:0]  pkt_count_o;
    logic [1:0]  err_code_o;
    logic [3:0]  err_src_o;

    bsg_mesh_proc_sink dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .en_i(en_i), .my_x_i(my_x_i), .my_y_i(my_y_i),
        .expected_pkts_i(expected_pkts_i), .v_i(v_i), .data_i(data_i), .ready_o(ready_o),
        .pkt_count_o(pkt_count_o), .done_o(done_o), .err_o(err_o), .err_code_o(err_code_o),
        .err_src_o(err_src_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [3:0] seq;
        logic [3:0] src;
        logic [3:0] dest;
    } pkt_t;

    typedef struct packed {
        logic [7:0] cnt;
        logic       err;
        logic [1:0] code;
        logic [3:0] src;
        logic       done;
    } exp_t;

    int   checks = 0, failures = 0;
    exp_t sb[$];
    exp_t e;
    pkt_t q[$];

    logic [3:0] m_exp [16];
    int         m_cnt, m_total, m_code, m_src;
    bit         m_err;
    logic [1:0] tx, ty;

    task automatic chk(string name, int act, int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d @%0t", name, act, req, $time);
        end
    endtask

    // Packet-level reference: what the sink must report after consuming p.
    task automatic model(pkt_t p);
        int code;
        code = (p.dest != {ty, tx}) ? 1 : (p.seq != m_exp[p.src]) ? 3 : 0;
        if (code != 0 && !m_err) begin
            m_err  = 1;
            m_code = code;
            m_src  = int'(p.src);
        end
        m_exp[p.src] = p.seq + 4'd1;
        if (m_cnt < 255) m_cnt++;
        sb.push_back('{cnt: 8'(m_cnt), err: m_err, code: 2'(m_code), src: 4'(m_src),
                       done: (m_cnt == m_total)});
    endtask

    logic acc_d = 1'b0;
    always @(posedge clk_i) acc_d <= v_i & ready_o;

    always @(negedge clk_i) begin
        if (acc_d) begin
            if (sb.size() == 0) chk("sb_underflow", 1, 0);
            else begin
                e = sb.pop_front();
                chk("count", int'(pkt_count_o), int'(e.cnt));
                chk("err", int'(err_o), int'(e.err));
                chk("err_code", int'(err_code_o), int'(e.code));
                chk("err_src", int'(err_src_o), int'(e.src));
                chk("done", int'(done_o), int'(e.done));
            end
        end
    end

    task automatic start(logic [1:0] x, logic [1:0] y, int total);
        reset_n_i = 1'b0;
        v_i = 1'b0;
        en_i = 1'b0;
        #1;
        chk("rst_ready", int'(ready_o), 0);
        chk("rst_done", int'(done_o), 0);
        chk("rst_err", int'(err_o), 0);
        chk("rst_cnt", int'(pkt_count_o), 0);
        chk("rst_code_src", int'({err_code_o, err_src_o}), 0);
        chk("sb_drained", sb.size(), 0);
        sb.delete();
        q.delete();
        tx = x; ty = y; my_x_i = x; my_y_i = y;
        for (int i = 0; i < 16; i++) m_exp[i] = '0;
        m_cnt = 0; m_total = total; m_err = 0; m_code = 0; m_src = 0;
        @(negedge clk_i);
        reset_n_i = 1'b1;
        @(negedge clk_i);
        en_i = 1'b1;
        expected_pkts_i = 8'(total);
        @(negedge clk_i);
        en_i = 1'b0;
        expected_pkts_i = 8'hFF;
        chk("start_done", int'(done_o), int'(total == 0));
    endtask

    task automatic run_q(int gap_pct);
        int budget = 3000;
        while (q.size() > 0 && budget > 0) begin
            budget--;
            if ($urandom_range(99) < gap_pct) begin
                v_i = 1'b0;
                @(negedge clk_i);
                continue;
            end
            v_i = 1'b1;
            data_i = q[0];
            if (ready_o) begin
                model(q[0]);
                q.delete(0);
            end
            @(negedge clk_i);
            if (m_total != 0 && m_cnt >= m_total) break;
        end
        v_i = 1'b0;
        if (budget == 0) chk("timeout", 0, 1);
    endtask

    function automatic pkt_t mk(int seq, int src, logic [1:0] x, logic [1:0] y);
        return '{seq: 4'(seq), src: 4'(src), dest: {y, x}};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL global_timeout");
        $fatal(1, "global timeout");
    end

    initial begin
        // every source once, seq 0
        start(2'd1, 2'd2, 16);
        for (int s = 0; s < 16; s++) q.push_back(mk(0, s, 2'd1, 2'd2));
        run_q(0);
        chk("t1_done", int'(done_o), 1);
        chk("t1_cnt", int'(pkt_count_o), 16);
        chk("t1_err", int'(err_o), 0);

        // dropped seq 2 on src 5, resync on seq 4
        start(2'd1, 2'd2, 4);
        foreach (q[i]) ;
        q.push_back(mk(0, 5, 2'd1, 2'd2));
        q.push_back(mk(1, 5, 2'd1, 2'd2));
        q.push_back(mk(3, 5, 2'd1, 2'd2));
        q.push_back(mk(4, 5, 2'd1, 2'd2));
        run_q(30);
        chk("t2_err", int'(err_o), 1);
        chk("t2_code", int'(err_code_o), 3);
        chk("t2_src", int'(err_src_o), 5);

        // wrong dest first, later seq error must not overwrite
        start(2'd1, 2'd2, 2);
        q.push_back(mk(0, 1, 2'd2, 2'd2));
        q.push_back(mk(5, 1, 2'd1, 2'd2));
        run_q(0);
        chk("t3_code", int'(err_code_o), 1);
        chk("t3_src", int'(err_src_o), 1);

        // sequence wrap on src 3
        start(2'd3, 2'd0, 17);
        for (int i = 0; i < 17; i++) q.push_back(mk(i % 16, 3, 2'd3, 2'd0));
        run_q(0);
        chk("t4_done", int'(done_o), 1);
        chk("t4_err", int'(err_o), 0);

        // more queued than expected: surplus is never consumed
        start(2'd0, 2'd1, 4);
        for (int i = 0; i < 6; i++) q.push_back(mk(i, 7, 2'd0, 2'd1));
        run_q(0);
        v_i = 1'b1;
        data_i = q[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            chk("t5_ready_low", int'(ready_o), 0);
            chk("t5_cnt_hold", int'(pkt_count_o), 4);
        end
        v_i = 1'b0;
        chk("t5_left", q.size(), 2);

        // asynchronous reset mid-RUN, then a clean restart
        start(2'd2, 2'd3, 10);
        for (int i = 0; i < 3; i++) q.push_back(mk(i, 9, 2'd2, 2'd3));
        run_q(0);
        chk("t6_cnt", int'(pkt_count_o), 3);
        v_i = 1'b1;
        data_i = mk(3, 9, 2'd2, 2'd3);
        #2;
        reset_n_i = 1'b0;
        #1;
        chk("t6_ready_drop", int'(ready_o), 0);
        chk("t6_cnt_clr", int'(pkt_count_o), 0);
        v_i = 1'b0;
        start(2'd2, 2'd3, 3);
        for (int i = 0; i < 3; i++) q.push_back(mk(i, 9, 2'd2, 2'd3));
        run_q(0);
        chk("t6_done", int'(done_o), 1);
        chk("t6_err", int'(err_o), 0);

        // zero expected goes straight to DONE
        start(2'd0, 2'd0, 0);
        v_i = 1'b1;
        data_i = mk(0, 0, 2'd0, 2'd0);
        @(negedge clk_i);
        chk("t7_ready", int'(ready_o), 0);
        chk("t7_cnt", int'(pkt_count_o), 0);
        v_i = 1'b0;

        // randomized traffic with drops, bad dests and idle gaps
        for (int r = 0; r < 6; r++) begin
            int         total;
            logic [3:0] g_exp [16];
            logic [1:0] x, y;
            x = 2'($urandom_range(3));
            y = 2'($urandom_range(3));
            total = $urandom_range(10, 40);
            start(x, y, total);
            for (int i = 0; i < 16; i++) g_exp[i] = '0;
            for (int i = 0; i < total; i++) begin
                int         s;
                logic [3:0] sq, d;
                s = $urandom_range(15);
                sq = g_exp[s] + (($urandom_range(9) == 0) ? 4'($urandom_range(1, 3)) : 4'd0);
                g_exp[s] = sq + 4'd1;
                d = {y, x};
                if ($urandom_range(19) == 0) d = d ^ 4'($urandom_range(1, 15));
                q.push_back('{seq: sq, src: 4'(s), dest: d});
            end
            run_q(20);
            chk("rand_done", int'(done_o), 1);
            chk("rand_cnt", int'(pkt_count_o), total);
            chk("rand_err", int'(err_o), int'(m_err));
        end

        @(negedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
